// File: rtl/comb_decimator_pkg.sv
// comb_decimator_pkg: shared widths, limits and sizing helpers for the CIC comb decimator.
package comb_decimator_pkg;
    localparam int n_default = 8;
    localparam int m_default = 9;
    localparam int r_max = 256;
    localparam int s_max = 8;

    function automatic int ctr_width(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    function automatic bit cfg_ok(input int n, input int m, input int r, input int s);
        return (m >= n) && (r >= 1) && (r <= r_max) && (s >= 1) && (s <= s_max);
    endfunction
endpackage

// File: rtl/comb_decimator_stage.sv
// comb_stage: one first-difference stage, y = x - previous x, registered on each input strobe.
module comb_stage #(
    parameter int m = 9
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [m-1:0] x,
    input  logic         x_valid,
    output logic [m-1:0] y,
    output logic         y_valid
);
    logic [m-1:0] d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            d       <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= x_valid;
            if (x_valid) begin
                y <= x - d;
                d <= x;
            end
        end
    end
endmodule

// File: rtl/comb_decimator.sv
// comb_decimator: keeps every r-th valid sample, sign-extends it to m bits and
// runs it through s cascaded comb stages (modulo 2^m, matching the integrator wrap).
module comb_decimator
    import comb_decimator_pkg::*;
#(
    parameter int n = n_default,
    parameter int m = m_default,
    parameter int r = 1,
    parameter int s = 1
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [n-1:0] in,
    input  logic         in_valid,
    output logic [m-1:0] out,
    output logic         out_valid
);
    localparam int cw = ctr_width(r);
    localparam logic [cw-1:0] last = cw'(r - 1);

    if (!cfg_ok(n, m, r, s)) begin : g_cfg_err
        $error("comb_decimator: need m >= n, 1 <= r <= 256, 1 <= s <= 8");
    end

    logic [cw-1:0] cnt;
    logic          keep;
    logic [m-1:0]  xs [s+1];
    logic          vs [s+1];

    assign keep = in_valid && (cnt == last);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt   <= '0;
            xs[0] <= '0;
            vs[0] <= 1'b0;
        end else begin
            vs[0] <= keep;
            if (in_valid) cnt <= keep ? '0 : cnt + 1'b1;
            if (keep) xs[0] <= m'($signed(in));
        end
    end

    for (genvar k = 0; k < s; k++) begin : g_stage
        comb_stage #(.m(m)) u_stage (
            .clk     (clk),
            .clr_n   (clr_n),
            .x       (xs[k]),
            .x_valid (vs[k]),
            .y       (xs[k+1]),
            .y_valid (vs[k+1])
        );
    end

    assign out       = xs[s];
    assign out_valid = vs[s];
endmodule

// File: tb/tb_comb_decimator.sv
// tb_comb_decimator: six configurations of comb_decimator checked by per-instance
// scoreboards that match both the value and the cycle of every out_valid strobe.
module tb_comb_decimator;
    typedef struct {
        int v;
        int due;
    } exp_t;

    logic       clk;
    logic       rn   [6];
    logic [7:0] din  [6];
    logic       vin  [6];
    logic       vo   [6];
    logic [8:0] o_a, o_b, o_c, o_e, o_f;
    logic [7:0] o_d;
    int         got  [6];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    exp_t       q [6][$];

    comb_decimator #(.n(8), .m(9), .r(1), .s(1)) u_a (.clk(clk), .clr_n(rn[0]), .in(din[0]), .in_valid(vin[0]), .out(o_a), .out_valid(vo[0]));
    comb_decimator #(.n(8), .m(9), .r(1), .s(2)) u_b (.clk(clk), .clr_n(rn[1]), .in(din[1]), .in_valid(vin[1]), .out(o_b), .out_valid(vo[1]));
    comb_decimator #(.n(8), .m(9), .r(4), .s(1)) u_c (.clk(clk), .clr_n(rn[2]), .in(din[2]), .in_valid(vin[2]), .out(o_c), .out_valid(vo[2]));
    comb_decimator #(.n(8), .m(8), .r(1), .s(1)) u_d (.clk(clk), .clr_n(rn[3]), .in(din[3]), .in_valid(vin[3]), .out(o_d), .out_valid(vo[3]));
    comb_decimator #(.n(8), .m(9), .r(2), .s(1)) u_e (.clk(clk), .clr_n(rn[4]), .in(din[4]), .in_valid(vin[4]), .out(o_e), .out_valid(vo[4]));
    comb_decimator #(.n(8), .m(9), .r(1), .s(3)) u_f (.clk(clk), .clr_n(rn[5]), .in(din[5]), .in_valid(vin[5]), .out(o_f), .out_valid(vo[5]));

    always_comb begin
        got[0] = $signed(o_a);
        got[1] = $signed(o_b);
        got[2] = $signed(o_c);
        got[3] = $signed(o_d);
        got[4] = $signed(o_e);
        got[5] = $signed(o_f);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 6; g++) begin : g_mon
        always @(negedge clk) begin
            if (vo[g]) begin
                exp_t e;
                checks++;
                if (q[g].size() == 0) begin
                    failures++;
                    $display("FAIL strobe[%0d] unexpected out=%0d at_cyc=%0d", g, got[g], cyc);
                end else begin
                    e = q[g].pop_front();
                    if (got[g] != e.v || cyc != e.due) begin
                        failures++;
                        $display("FAIL out[%0d] got=%0d at_cyc=%0d expected=%0d at_cyc=%0d", g, got[g], cyc, e.v, e.due);
                    end
                end
            end
        end
    end

    // Inputs change 1 time unit after a rising edge; a strobe for a kept sample
    // driven at cycle c is seen by the monitor at cycle c + s + 1.
    task automatic send(input int i, input int v, input bit val, input bit keep, input int e, input int s);
        if (keep) q[i].push_back('{e, cyc + s + 1});
        din[i] = 8'(v);
        vin[i] = val;
        @(posedge clk);
        #1;
        vin[i] = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input int i, input string name);
        checks++;
        if (got[i] != 0 || vo[i] !== 1'b0) begin
            failures++;
            $display("FAIL %s[%0d] out=%0d out_valid=%b expected out=0 out_valid=0", name, i, got[i], vo[i]);
        end
    endtask

    initial begin
        int e_vals [7] = '{10, 0, 0, 20, 30, 0, 40};
        bit e_vld  [7] = '{1, 0, 0, 1, 1, 0, 1};
        bit e_keep [7] = '{0, 0, 0, 1, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            rn[i]  = 1'b0;
            vin[i] = 1'b0;
            din[i] = '0;
        end
        #2;
        for (int i = 0; i < 6; i++) chk_zero(i, "reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) rn[i] = 1'b1;
        idle(1);
        send(0, 33, 1, 1, 33, 1);
        send(0, 26, 1, 1, -7, 1);
        send(0, -9, 1, 1, -35, 1);
        send(0, -2, 1, 1, 7, 1);
        idle(3);
        send(1, 5, 1, 1, 5, 2);
        send(1, 5, 1, 1, -5, 2);
        send(1, 5, 1, 1, 0, 2);
        send(1, 5, 1, 1, 0, 2);
        idle(4);
        for (int i = 0; i < 16; i++) send(2, i, 1, (i % 4) == 3, (i == 3) ? 3 : 4, 1);
        idle(3);
        send(3, 127, 1, 1, 127, 1);
        send(3, -128, 1, 1, 1, 1);
        idle(3);
        for (int i = 0; i < 7; i++) send(4, e_vals[i], e_vld[i], e_keep[i], 20, 1);
        idle(3);
        send(5, 3, 1, 1, 3, 3);
        idle(5);
        send(5, 7, 1, 0, 0, 3);
        rn[5] = 1'b0;
        #1;
        chk_zero(5, "midreset");
        idle(4);
        chk_zero(5, "held_reset");
        rn[5] = 1'b1;
        send(5, 9, 1, 1, 9, 3);
        idle(6);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (q[i].size() != 0) begin
                failures++;
                $display("FAIL drain[%0d] outstanding=%0d expected=0", i, q[i].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
